// File: rtl/toggle_evt_pkg.sv
// rtl/toggle_evt_pkg.sv - shared constants and width helpers for the toggle event collector
package toggle_evt_pkg;

    localparam int MIN_SYNC_STAGES = 2;
    localparam int MAX_CHANNELS    = 32;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Channel-index width, never narrower than one bit.
    function automatic int ch_width(input int channels);
        return (clog2(channels) < 1) ? 1 : clog2(channels);
    endfunction

endpackage

// File: rtl/toggle_edge_sync.sv
// rtl/toggle_edge_sync.sv - multi-flop synchroniser plus toggle-to-pulse edge detect for one channel
module toggle_edge_sync
    import toggle_evt_pkg::*;
#(
    parameter int SYNC_STAGES = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic toggle_in,
    output logic pulse_out
);

    // Timing hook: toggle_in -> r_sync[0] is the asynchronous crossing; constrain it
    // with a false path / max delay on this instance's r_sync[0] D pin.
    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] r_sync;
    logic r_hist;
    logic r_pulse;

    // Shift the asynchronous level through the synchroniser, keep one history flop
    // and register the edge so the pulse is glitch-free and exactly one cycle wide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= '0;
            r_hist  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], toggle_in};
            r_hist  <= r_sync[SYNC_STAGES-1];
            r_pulse <= r_sync[SYNC_STAGES-1] ^ r_hist;
        end
    end

    assign pulse_out = r_pulse;

endmodule

// File: rtl/toggle_event_collector.sv
// rtl/toggle_event_collector.sv - multi-channel toggle receiver with pending counters and round-robin event port
module toggle_event_collector
    import toggle_evt_pkg::*;
#(
    parameter  int CHANNELS    = 4,
    parameter  int SYNC_STAGES = 3,
    parameter  int CNT_W       = 4,
    localparam int CH_W        = ch_width(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] toggle_in,
    output logic [CHANNELS-1:0] pulse_out,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [CH_W-1:0]     evt_chan,
    output logic [CHANNELS-1:0] overflow,
    input  logic                ovf_clr,
    output logic                pending_any
);

    localparam int              IDX_W   = CH_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync_stages
        $error("toggle_event_collector: SYNC_STAGES must be at least %0d", MIN_SYNC_STAGES);
    end
    if (CHANNELS < 1 || CHANNELS > MAX_CHANNELS) begin : g_bad_channels
        $error("toggle_event_collector: CHANNELS must be in 1..%0d", MAX_CHANNELS);
    end

    logic [CHANNELS-1:0] w_pulse;
    logic [CNT_W-1:0]    r_cnt [CHANNELS];
    logic [CHANNELS-1:0] r_ovf;
    logic [CH_W-1:0]     r_rr_ptr;
    logic                r_evt_valid;
    logic [CH_W-1:0]     r_evt_chan;

    logic [CHANNELS-1:0] w_nonzero;
    logic                w_any;
    logic [CH_W-1:0]     w_cand [CHANNELS];
    logic                w_found;
    logic [CH_W-1:0]     w_pick;
    logic                w_load;
    logic [CHANNELS-1:0] w_dec;
    logic [CH_W-1:0]     w_next_ptr;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        logic [IDX_W-1:0] w_sum;

        toggle_edge_sync #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .clk       (clk),
            .rst_n     (rst_n),
            .toggle_in (toggle_in[g]),
            .pulse_out (w_pulse[g])
        );

        // Candidate channel g positions after the RR pointer, wrapped modulo CHANNELS.
        assign w_sum     = {1'b0, r_rr_ptr} + IDX_W'(g);
        assign w_cand[g] = (w_sum >= IDX_W'(CHANNELS)) ? CH_W'(w_sum - IDX_W'(CHANNELS))
                                                      : CH_W'(w_sum);
    end

    // Flag channels with queued events; pending_any looks only at the counters.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            w_nonzero[c] = (r_cnt[c] != '0);
        end
    end

    assign w_any = |w_nonzero;

    // Round-robin pick: first non-zero counter at or after the pointer.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (!w_found && w_nonzero[w_cand[i]]) begin
                w_found = 1'b1;
                w_pick  = w_cand[i];
            end
        end
    end

    assign w_load     = (!r_evt_valid || evt_ready) && w_any;
    assign w_next_ptr = (w_pick == CH_W'(CHANNELS - 1)) ? '0 : w_pick + CH_W'(1);

    // One-hot decrement for the channel moved into the output register.
    always_comb begin
        w_dec = '0;
        if (w_load) begin
            w_dec[w_pick] = 1'b1;
        end
    end

    // Pending counters: +1 on pulse, -1 on load, unchanged on both, saturate at max.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_cnt[c] <= '0;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                case ({w_pulse[c], w_dec[c]})
                    2'b10: begin
                        if (r_cnt[c] != CNT_MAX) begin
                            r_cnt[c] <= r_cnt[c] + CNT_W'(1);
                        end
                    end
                    2'b01:   r_cnt[c] <= r_cnt[c] - CNT_W'(1);
                    default: r_cnt[c] <= r_cnt[c];
                endcase
            end
        end
    end

    // Sticky overflow per channel; a new drop in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (w_pulse[c] && !w_dec[c] && (r_cnt[c] == CNT_MAX)) begin
                    r_ovf[c] <= 1'b1;
                end else if (ovf_clr) begin
                    r_ovf[c] <= 1'b0;
                end
            end
        end
    end

    // Output register and RR pointer: load when empty or being accepted, hold under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_evt_valid <= 1'b0;
            r_evt_chan  <= '0;
            r_rr_ptr    <= '0;
        end else if (w_load) begin
            r_evt_valid <= 1'b1;
            r_evt_chan  <= w_pick;
            r_rr_ptr    <= w_next_ptr;
        end else if (evt_ready) begin
            r_evt_valid <= 1'b0;
        end
    end

    assign pulse_out   = w_pulse;
    assign evt_valid   = r_evt_valid;
    assign evt_chan    = r_evt_chan;
    assign overflow    = r_ovf;
    assign pending_any = w_any;

endmodule

// File: tb/tb_toggle_event_collector.sv
// tb/tb_toggle_event_collector.sv - directed self-checking bench for toggle_event_collector
module tb_toggle_event_collector;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] toggle_in;
    logic [3:0] pulse_out;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_chan;
    logic [3:0] overflow;
    logic       ovf_clr;
    logic       pending_any;

    logic [0:0] b_toggle;
    logic [0:0] b_pulse;
    logic       b_valid;
    logic       b_ready;
    logic [0:0] b_chan;
    logic [0:0] b_overflow;
    logic       b_ovf_clr;
    logic       b_pending;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    toggle_event_collector #(
        .CHANNELS    (4),
        .SYNC_STAGES (3),
        .CNT_W       (4)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .toggle_in   (toggle_in),
        .pulse_out   (pulse_out),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_chan    (evt_chan),
        .overflow    (overflow),
        .ovf_clr     (ovf_clr),
        .pending_any (pending_any)
    );

    toggle_event_collector #(
        .CHANNELS    (1),
        .SYNC_STAGES (2),
        .CNT_W       (4)
    ) u_dut_one (
        .clk         (clk),
        .rst_n       (rst_n),
        .toggle_in   (b_toggle),
        .pulse_out   (b_pulse),
        .evt_valid   (b_valid),
        .evt_ready   (b_ready),
        .evt_chan    (b_chan),
        .overflow    (b_overflow),
        .ovf_clr     (b_ovf_clr),
        .pending_any (b_pending)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [3:0] level);
        rst_n     = 1'b0;
        toggle_in = level;
        tick(2);
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic drain_count(input int cycles, output int n);
        n = 0;
        evt_ready = 1'b1;
        repeat (cycles) begin
            if (evt_valid) n++;
            tick(1);
        end
    endtask

    task automatic wait_pulse(input int ch, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick(1);
            if (pulse_out[ch]) seen = 1'b1;
        end
    endtask

    initial begin
        int   n;
        int   bad;
        logic seen;

        rst_n     = 1'b0;
        toggle_in = '0;
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;
        b_toggle  = '0;
        b_ready   = 1'b0;
        b_ovf_clr = 1'b0;
        #2;
        check("rst_valid",   32'(evt_valid),   0);
        check("rst_chan",    32'(evt_chan),    0);
        check("rst_pulse",   32'(pulse_out),   0);
        check("rst_ovf",     32'(overflow),    0);
        check("rst_pending", 32'(pending_any), 0);
        tick(2);
        rst_n = 1'b1;
        tick(3);

        // 1: single toggle on channel 2
        evt_ready    = 1'b1;
        toggle_in[2] = 1'b1;
        tick(3);
        check("t1_pulse_early", 32'(pulse_out), 0);
        tick(1);
        check("t1_pulse", 32'(pulse_out), 32'h4);
        tick(1);
        check("t1_pulse_one_cycle", 32'(pulse_out), 0);
        check("t1_pending", 32'(pending_any), 1);
        check("t1_valid_before", 32'(evt_valid), 0);
        tick(1);
        check("t1_valid", 32'(evt_valid), 1);
        check("t1_chan", 32'(evt_chan), 2);
        tick(1);
        check("t1_valid_drop", 32'(evt_valid), 0);
        check("t1_pending_clear", 32'(pending_any), 0);

        // 2: round robin from pointer 0
        do_reset(4'b0000);
        toggle_in = 4'b1011;
        tick(4);
        check("t2_pulse", 32'(pulse_out), 32'hb);
        tick(2);
        check("t2_v0", 32'(evt_valid), 1);
        check("t2_c0", 32'(evt_chan), 0);
        tick(1);
        check("t2_v1", 32'(evt_valid), 1);
        check("t2_c1", 32'(evt_chan), 1);
        tick(1);
        check("t2_v2", 32'(evt_valid), 1);
        check("t2_c2", 32'(evt_chan), 3);
        tick(1);
        check("t2_idle", 32'(evt_valid), 0);
        toggle_in = toggle_in ^ 4'b1001;
        tick(6);
        check("t2r_c0", 32'(evt_chan), 0);
        tick(1);
        check("t2r_v1", 32'(evt_valid), 1);
        check("t2r_c1", 32'(evt_chan), 3);
        tick(1);
        check("t2r_idle", 32'(evt_valid), 0);

        // 3: backpressure and saturation on channel 1
        evt_ready = 1'b0;
        bad = 0;
        for (int k = 0; k < 16; k++) begin
            toggle_in[1] = ~toggle_in[1];
            repeat (3) begin
                tick(1);
                if (evt_valid && evt_chan != 2'd1) bad++;
            end
        end
        tick(6);
        check("t3_no_ovf_at_16", 32'(overflow), 0);
        toggle_in[1] = ~toggle_in[1];
        repeat (6) begin
            tick(1);
            if (evt_valid && evt_chan != 2'd1) bad++;
        end
        check("t3_chan_hold", bad, 0);
        check("t3_valid_held", 32'(evt_valid), 1);
        check("t3_chan", 32'(evt_chan), 1);
        check("t3_ovf", 32'(overflow), 32'h2);
        drain_count(40, n);
        check("t3_drained", n, 16);
        check("t3_pending_after", 32'(pending_any), 0);
        check("t3_ovf_sticky", 32'(overflow), 32'h2);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        check("t3_ovf_clr", 32'(overflow), 0);

        // 4a: increment and decrement of channel 0 in the same cycle
        evt_ready = 1'b0;
        toggle_in[0] = ~toggle_in[0];
        tick(3);
        toggle_in[0] = ~toggle_in[0];
        tick(8);
        check("t4_reg_ch0", 32'(evt_chan), 0);
        check("t4_cnt_one", 32'(pending_any), 1);
        toggle_in[0] = ~toggle_in[0];
        wait_pulse(0, seen);
        check("t4_pulse_seen", 32'(seen), 1);
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        check("t4_valid", 32'(evt_valid), 1);
        check("t4_chan", 32'(evt_chan), 0);
        check("t4_cnt_kept", 32'(pending_any), 1);
        check("t4_no_ovf", 32'(overflow), 0);
        drain_count(20, n);
        check("t4_drained", n, 2);

        // 4b: saturate channel 2, then a drop coincident with ovf_clr
        evt_ready = 1'b0;
        for (int k = 0; k < 17; k++) begin
            toggle_in[2] = ~toggle_in[2];
            tick(3);
        end
        tick(6);
        check("t4b_ovf", 32'(overflow), 32'h4);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        check("t4b_ovf_clr", 32'(overflow), 0);
        toggle_in[2] = ~toggle_in[2];
        wait_pulse(2, seen);
        check("t4b_pulse_seen", 32'(seen), 1);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        check("t4b_set_wins", 32'(overflow), 32'h4);
        drain_count(40, n);
        check("t4b_drained", n, 16);

        // 5: asynchronous reset with events queued
        evt_ready = 1'b0;
        toggle_in = toggle_in ^ 4'hf;
        tick(3);
        toggle_in[0] = ~toggle_in[0];
        tick(8);
        check("t5_pending", 32'(pending_any), 1);
        evt_ready = 1'b1;
        tick(1);
        #3;
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid",   32'(evt_valid),   0);
        check("t5_rst_chan",    32'(evt_chan),    0);
        check("t5_rst_pulse",   32'(pulse_out),   0);
        check("t5_rst_ovf",     32'(overflow),    0);
        check("t5_rst_pending", 32'(pending_any), 0);
        toggle_in = 4'b0000;
        tick(2);
        rst_n = 1'b1;
        drain_count(15, n);
        check("t5_quiet", n, 0);
        rst_n     = 1'b0;
        toggle_in = 4'b1000;
        tick(2);
        rst_n = 1'b1;
        n   = 0;
        bad = 0;
        repeat (15) begin
            if (evt_valid) begin
                n++;
                if (evt_chan != 2'd3) bad++;
            end
            tick(1);
        end
        check("t5_one_event", n, 1);
        check("t5_event_ch3", bad, 0);

        // 6: single-channel, two-stage instance
        b_ready  = 1'b1;
        b_toggle = 1'b1;
        tick(2);
        check("t6_pulse_early", 32'(b_pulse), 0);
        tick(1);
        check("t6_pulse", 32'(b_pulse), 1);
        tick(1);
        check("t6_pulse_one_cycle", 32'(b_pulse), 0);
        tick(1);
        check("t6_valid", 32'(b_valid), 1);
        check("t6_chan", 32'(b_chan), 0);
        tick(2);
        n   = 0;
        bad = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (cyc < 16 && (cyc % 2) == 0) b_toggle = ~b_toggle;
            if (b_valid) begin
                n++;
                if (b_chan != 1'b0) bad++;
            end
            tick(1);
        end
        check("t6_b2b_count", n, 8);
        check("t6_b2b_chan", bad, 0);
        check("t6_no_ovf", 32'(b_overflow), 0);
        check("t6_pending", 32'(b_pending), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
